decoder_dram_rreq_fsm: RTL and testbench

Read-request sequencer for the decoder's input side. It fetches each stego image from DRAM through the full AXI master as a fixed number of equal-length read bursts. Bursts go into the decoder input FIFO, and each image starts at a base address latched when `begin_decoding` is asserted. It sits between the register-file control (base address, start strobe) and the AXI master read channel. It is the read-side counterpart of the decoder's DRAM write-request sequencer.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_baddr_fifo.sv | 62 ++++++
 rtl/decoder_dram_rreq_fsm.sv | 138 +++++++++++++
 tb/tb_decoder_dram_rreq_fsm.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared decoder definitions: read-request sequencer state encoding and the
// burst byte-size helper used to step through an image in DRAM.
package decoder_pkg;

    typedef enum logic [2:0] {
        RREQ_IDLE        = 3'd0,
        GET_IMG_BADDR    = 3'd1,
        START_READ_IMG   = 3'd2,
        READ_IMG         = 3'd3,
        RREQ_DECIDE_NEXT = 3'd4
    } rreq_state_t;

    function automatic int unsigned bytes_per_burst(input int unsigned burst_len,
                                                    input int unsigned data_width);
        return (burst_len * data_width) / 8;
    endfunction

endpackage

// File: rtl/decoder_baddr_fifo.sv
// Image base-address queue with fall-through head; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module decoder_baddr_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         rd_ptr;
    logic [IW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + IW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + IW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge axi_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_addr;
        end
    end

endmodule

// File: rtl/decoder_dram_rreq_fsm.sv
// Decoder read-request sequencer: fetches each queued image as a fixed number of
// equal bursts. Define DECODER_RREQ_OVF_ERR_EN to flag dropped base-address pushes.
module decoder_dram_rreq_fsm
    import decoder_pkg::*;
#(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int IMG_RBURST_LEN     = 128,
    parameter int NUM_RREQS_PER_SIMG = 14,
    parameter int BADDR_FIFO_DEPTH   = 4
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic [ADDR_WIDTH-1:0] img_baddr,
    input  logic                  begin_decoding,
    input  logic                  axi_m_can_accept_rreq,
    input  logic                  rnext,
    input  logic                  infifo_has_room,
    output logic [ADDR_WIDTH-1:0] dram_raddr,
    output logic                  dram_rreq,
    output logic                  done_fetching,
    output logic                  rreq_busy,
    output logic                  baddr_ovf_err,
    output rreq_state_t           rreq_state
);

    localparam int BEAT_W  = $clog2(IMG_RBURST_LEN + 1);
    localparam int BURST_W = $clog2(NUM_RREQS_PER_SIMG + 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES =
        ADDR_WIDTH'(bytes_per_burst(IMG_RBURST_LEN, DATA_WIDTH));
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(IMG_RBURST_LEN);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_RREQS_PER_SIMG);

    rreq_state_t           state;
    logic [ADDR_WIDTH-1:0] head_q;
    logic [ADDR_WIDTH-1:0] img_addr;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BURST_W-1:0]    burst_cnt;
    logic [ADDR_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;

    assign fifo_pop   = (state == RREQ_IDLE) && !fifo_empty;
    assign dram_raddr = img_addr;
    assign rreq_state = state;

    decoder_baddr_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (BADDR_FIFO_DEPTH)
    ) u_baddr_fifo (
        .axi_clk   (axi_clk),
        .axi_reset (axi_reset),
        .push      (begin_decoding),
        .push_addr (img_baddr),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state         <= RREQ_IDLE;
            head_q        <= '0;
            img_addr      <= '0;
            beat_cnt      <= '0;
            burst_cnt     <= '0;
            dram_rreq     <= 1'b0;
            done_fetching <= 1'b0;
            rreq_busy     <= 1'b0;
        end else begin
            dram_rreq     <= 1'b0;
            done_fetching <= 1'b0;
            case (state)
                RREQ_IDLE: begin
                    if (!fifo_empty) begin
                        head_q    <= fifo_head;
                        rreq_busy <= 1'b1;
                        state     <= GET_IMG_BADDR;
                    end
                end
                GET_IMG_BADDR: begin
                    img_addr  <= head_q;
                    burst_cnt <= BURST_W'(1);
                    state     <= START_READ_IMG;
                end
                START_READ_IMG: begin
                    if (infifo_has_room && axi_m_can_accept_rreq) begin
                        dram_rreq <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= READ_IMG;
                    end
                end
                READ_IMG: begin
                    if (rnext) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt + BEAT_W'(1) == LAST_BEAT) begin
                            state <= RREQ_DECIDE_NEXT;
                        end
                    end
                end
                RREQ_DECIDE_NEXT: begin
                    if (burst_cnt == LAST_BURST) begin
                        done_fetching <= 1'b1;
                        rreq_busy     <= 1'b0;
                        state         <= RREQ_IDLE;
                    end else begin
                        // Address wraps silently at the top of the address space.
                        img_addr  <= img_addr + BURST_BYTES;
                        burst_cnt <= burst_cnt + BURST_W'(1);
                        state     <= START_READ_IMG;
                    end
                end
                default: begin
                    state <= RREQ_IDLE;
                end
            endcase
        end
    end

`ifdef DECODER_RREQ_OVF_ERR_EN
    logic push_dropped;

    assign push_dropped = begin_decoding && fifo_full && !fifo_pop;

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            baddr_ovf_err <= 1'b0;
        end else if (push_dropped) begin
            baddr_ovf_err <= 1'b1;
        end
    end
`else
    assign baddr_ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_dram_rreq_fsm.sv
// Bench for decoder_dram_rreq_fsm: directed scenarios plus randomized image
// streams checked against a burst-address/timing reference model.
module tb_decoder_dram_rreq_fsm;
  import decoder_pkg::*;

  localparam int AW  = 32;
  localparam int LEN = 4;
  localparam int NB  = 3;
  localparam int BPB = LEN * 32 / 8;

  logic          axi_clk = 1'b0;
  logic          axi_reset;
  logic [AW-1:0] img_baddr;
  logic          begin_decoding;
  logic          axi_m_can_accept_rreq;
  logic          rnext;
  logic          infifo_has_room;
  logic [AW-1:0] dram_raddr;
  logic          dram_rreq;
  logic          done_fetching;
  logic          rreq_busy;
  logic          baddr_ovf_err;
  rreq_state_t   rreq_state;

  logic rand_flow, can_rand, room_rand, can_set, room_set, spur_en;
  int   gap_max, beat_limit;
  int   cyc;
  int   strobe_cyc;
  int   n_cmp, n_fail;
  int   rreq_double;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] stb_q[$];
  logic [AW-1:0] rreq_addr_q[$];
  int            rreq_cyc_q[$];
  int            done_cyc_q[$];
  int            beat_cyc_q[$];

  assign axi_m_can_accept_rreq = rand_flow ? can_rand : can_set;
  assign infifo_has_room       = rand_flow ? room_rand : room_set;

  decoder_dram_rreq_fsm #(
    .ADDR_WIDTH         (AW),
    .DATA_WIDTH         (32),
    .IMG_RBURST_LEN     (LEN),
    .NUM_RREQS_PER_SIMG (NB),
    .BADDR_FIFO_DEPTH   (4)
  ) dut (
    .axi_clk               (axi_clk),
    .axi_reset             (axi_reset),
    .img_baddr             (img_baddr),
    .begin_decoding        (begin_decoding),
    .axi_m_can_accept_rreq (axi_m_can_accept_rreq),
    .rnext                 (rnext),
    .infifo_has_room       (infifo_has_room),
    .dram_raddr            (dram_raddr),
    .dram_rreq             (dram_rreq),
    .done_fetching         (done_fetching),
    .rreq_busy             (rreq_busy),
    .baddr_ovf_err         (baddr_ovf_err),
    .rreq_state            (rreq_state)
  );

  // clock / cycle counter
  initial forever #5 axi_clk = ~axi_clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge axi_clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // output monitor: logs request pulses and done pulses at the falling edge
  initial begin
    bit prev;
    prev = 1'b0;
    rreq_double = 0;
    forever begin
      @(negedge axi_clk);
      if (axi_reset) begin
        prev = 1'b0;
      end else begin
        if (dram_rreq) begin
          rreq_addr_q.push_back(dram_raddr);
          rreq_cyc_q.push_back(cyc);
          if (prev) rreq_double++;
        end
        prev = dram_rreq;
        if (done_fetching) done_cyc_q.push_back(cyc);
      end
    end
  end

  // random flow-control source
  initial begin
    can_rand = 1'b1;
    room_rand = 1'b1;
    forever begin
      @(negedge axi_clk);
      can_rand  = ($urandom_range(0, 3) != 0);
      room_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // read-data responder: delivers beats after each request pulse
  initial begin
    int g;
    rnext = 1'b0;
    forever begin
      @(negedge axi_clk);
      if (dram_rreq && !axi_reset) begin
        for (int b = 0; b < beat_limit; b++) begin
          g = $urandom_range(0, gap_max);
          repeat (g) begin
            rnext = 1'b0;
            @(negedge axi_clk);
          end
          rnext = 1'b1;
          beat_cyc_q.push_back(cyc);
          @(negedge axi_clk);
          rnext = 1'b0;
        end
      end else begin
        rnext = spur_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge axi_clk);
    #1;
  endtask

  task automatic clear_logs();
    rreq_addr_q.delete();
    rreq_cyc_q.delete();
    done_cyc_q.delete();
    beat_cyc_q.delete();
    exp_q.delete();
    stb_q.delete();
    rreq_double = 0;
  endtask

  task automatic add_image(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    a = base;
    stb_q.push_back(base);
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(a);
      a = a + AW'(BPB);
    end
  endtask

  task automatic strobe_all();
    for (int i = 0; i < stb_q.size(); i++) begin
      step();
      img_baddr = stb_q[i];
      begin_decoding = 1'b1;
      if (i == 0) strobe_cyc = cyc;
    end
    step();
    begin_decoding = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // scenarios
  task automatic test_reset();
    n_cmp++; if (dram_raddr !== '0) begin n_fail++; $display("FAIL reset_raddr got=%0h exp=0", dram_raddr); end
    n_cmp++; if (dram_rreq !== 1'b0) begin n_fail++; $display("FAIL reset_rreq got=%0b exp=0", dram_rreq); end
    n_cmp++; if (done_fetching !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done_fetching); end
    n_cmp++; if (rreq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", rreq_busy); end
    n_cmp++; if (baddr_ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0b exp=0", baddr_ovf_err); end
    n_cmp++; if (rreq_state !== RREQ_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", rreq_state, RREQ_IDLE); end
  endtask

  task automatic test_single_image();
    bit ok;
    clear_logs();
    add_image(32'h0000_1000);
    strobe_all();
    wait_dones(1, 300, ok);
    step();
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout got=%0d dones exp=1", done_cyc_q.size()); end
    n_cmp++; if (rreq_addr_q.size() !== NB) begin n_fail++; $display("FAIL single_nreq got=%0d exp=%0d", rreq_addr_q.size(), NB); end
    for (int i = 0; i < exp_q.size() && i < rreq_addr_q.size(); i++) begin
      n_cmp++; if (rreq_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_addr[%0d] got=%0h exp=%0h", i, rreq_addr_q[i], exp_q[i]); end
    end
    if (rreq_cyc_q.size() > 0) begin
      n_cmp++; if (rreq_cyc_q[0] !== strobe_cyc + 4) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", rreq_cyc_q[0] - strobe_cyc, 4); end
    end
    if (done_cyc_q.size() > 0 && beat_cyc_q.size() >= NB * LEN) begin
      n_cmp++; if (done_cyc_q[0] !== beat_cyc_q[NB*LEN-1] + 2) begin n_fail++; $display("FAIL single_done_time got=%0d exp=%0d", done_cyc_q[0], beat_cyc_q[NB*LEN-1] + 2); end
    end
    n_cmp++; if (rreq_double !== 0) begin n_fail++; $display("FAIL single_rreq_width got=%0d exp=0", rreq_double); end
    n_cmp++; if (rreq_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got=%0b exp=0", rreq_busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r;
    clear_logs();
    add_image(32'h0000_6000);
    strobe_all();
    for (int i = 0; i < 50 && rreq_cyc_q.size() == 0; i++) step();
    room_set = 1'b0;
    repeat (10) step();
    n_cmp++; if (rreq_cyc_q.size() !== 1) begin n_fail++; $display("FAIL bp_blocked got=%0d reqs exp=1", rreq_cyc_q.size()); end
    room_set = 1'b1;
    r = cyc;
    wait_dones(1, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%0d dones exp=1", done_cyc_q.size()); end
    if (rreq_cyc_q.size() > 1) begin
      n_cmp++; if (rreq_cyc_q[1] !== r + 1) begin n_fail++; $display("FAIL bp_resume got=%0d exp=%0d", rreq_cyc_q[1], r + 1); end
    end
    for (int i = 0; i < exp_q.size() && i < rreq_addr_q.size(); i++) begin
      n_cmp++; if (rreq_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_addr[%0d] got=%0h exp=%0h", i, rreq_addr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_two_images();
    bit ok;
    clear_logs();
    add_image(32'h0000_2000);
    add_image(32'h0000_8000);
    strobe_all();
    wait_dones(2, 600, ok);
    repeat (5) step();
    n_cmp++; if (done_cyc_q.size() !== 2) begin n_fail++; $display("FAIL two_dones got=%0d exp=2", done_cyc_q.size()); end
    n_cmp++; if (rreq_addr_q.size() !== 2 * NB) begin n_fail++; $display("FAIL two_nreq got=%0d exp=%0d", rreq_addr_q.size(), 2 * NB); end
    for (int i = 0; i < exp_q.size() && i < rreq_addr_q.size(); i++) begin
      n_cmp++; if (rreq_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL two_addr[%0d] got=%0h exp=%0h", i, rreq_addr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic exp_ovf;
`ifdef DECODER_RREQ_OVF_ERR_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    clear_logs();
    can_set = 1'b0;
    add_image(32'h0000_4000);
    strobe_all();
    repeat (4) step();
    n_cmp++; if (rreq_busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy got=%0b exp=1", rreq_busy); end
    // image A is already popped; four more fill the queue and the fifth is dropped
    stb_q.delete();
    add_image(32'h0001_0000);
    add_image(32'h0002_0000);
    add_image(32'h0003_0000);
    add_image(32'h0004_0000);
    stb_q.push_back(32'h0005_0000);
    strobe_all();
    step();
    n_cmp++; if (baddr_ovf_err !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag got=%0b exp=%0b", baddr_ovf_err, exp_ovf); end
    n_cmp++; if (rreq_addr_q.size() !== 0) begin n_fail++; $display("FAIL ovf_blocked got=%0d reqs exp=0", rreq_addr_q.size()); end
    can_set = 1'b1;
    wait_dones(5, 1000, ok);
    repeat (60) step();
    n_cmp++; if (done_cyc_q.size() !== 5) begin n_fail++; $display("FAIL ovf_dones got=%0d exp=5", done_cyc_q.size()); end
    n_cmp++; if (rreq_addr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_nreq got=%0d exp=%0d", rreq_addr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rreq_addr_q.size(); i++) begin
      n_cmp++; if (rreq_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_addr[%0d] got=%0h exp=%0h", i, rreq_addr_q[i], exp_q[i]); end
    end
    n_cmp++; if (baddr_ovf_err !== exp_ovf) begin n_fail++; $display("FAIL ovf_sticky got=%0b exp=%0b", baddr_ovf_err, exp_ovf); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    add_image(32'hFFFF_FFF0);
    strobe_all();
    wait_dones(1, 300, ok);
    n_cmp++; if (rreq_addr_q.size() !== NB) begin n_fail++; $display("FAIL wrap_nreq got=%0d exp=%0d", rreq_addr_q.size(), NB); end
    for (int i = 0; i < exp_q.size() && i < rreq_addr_q.size(); i++) begin
      n_cmp++; if (rreq_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got=%0h exp=%0h", i, rreq_addr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midburst();
    bit ok;
    clear_logs();
    beat_limit = 2;
    add_image(32'h0000_5000);
    strobe_all();
    for (int i = 0; i < 60 && beat_cyc_q.size() < 2; i++) step();
    repeat (2) step();
    n_cmp++; if (rreq_state !== READ_IMG) begin n_fail++; $display("FAIL rst_pre_state got=%0d exp=%0d", rreq_state, READ_IMG); end
    n_cmp++; if (dram_raddr !== 32'h0000_5000) begin n_fail++; $display("FAIL rst_pre_raddr got=%0h exp=5000", dram_raddr); end
    axi_reset = 1'b1;
    #1;
    n_cmp++; if (dram_raddr !== '0) begin n_fail++; $display("FAIL rst_async_raddr got=%0h exp=0", dram_raddr); end
    n_cmp++; if (dram_rreq !== 1'b0) begin n_fail++; $display("FAIL rst_async_rreq got=%0b exp=0", dram_rreq); end
    n_cmp++; if (done_fetching !== 1'b0) begin n_fail++; $display("FAIL rst_async_done got=%0b exp=0", done_fetching); end
    n_cmp++; if (rreq_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%0b exp=0", rreq_busy); end
    n_cmp++; if (baddr_ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_ovf got=%0b exp=0", baddr_ovf_err); end
    n_cmp++; if (rreq_state !== RREQ_IDLE) begin n_fail++; $display("FAIL rst_async_state got=%0d exp=%0d", rreq_state, RREQ_IDLE); end
    repeat (2) step();
    axi_reset = 1'b0;
    beat_limit = LEN;
    step();
    clear_logs();
    add_image(32'h0000_3000);
    strobe_all();
    wait_dones(1, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_after_timeout got=%0d dones exp=1", done_cyc_q.size()); end
    if (rreq_cyc_q.size() > 0) begin
      n_cmp++; if (rreq_cyc_q[0] !== strobe_cyc + 4) begin n_fail++; $display("FAIL rst_after_latency got=%0d exp=4", rreq_cyc_q[0] - strobe_cyc); end
    end
    for (int i = 0; i < exp_q.size() && i < rreq_addr_q.size(); i++) begin
      n_cmp++; if (rreq_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_after_addr[%0d] got=%0h exp=%0h", i, rreq_addr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) add_image($urandom);
      gap_max = $urandom_range(0, 2);
      rand_flow = 1'b1;
      spur_en = 1'b1;
      strobe_all();
      wait_dones(n, 3000, ok);
      rand_flow = 1'b0;
      spur_en = 1'b0;
      repeat (5) step();
      n_cmp++; if (done_cyc_q.size() !== n) begin n_fail++; $display("FAIL rand%0d_dones got=%0d exp=%0d", it, done_cyc_q.size(), n); end
      n_cmp++; if (rreq_addr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_nreq got=%0d exp=%0d", it, rreq_addr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rreq_addr_q.size(); i++) begin
        n_cmp++; if (rreq_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_addr[%0d] got=%0h exp=%0h", it, i, rreq_addr_q[i], exp_q[i]); end
      end
      for (int m = 0; m < done_cyc_q.size() && (m + 1) * NB * LEN <= beat_cyc_q.size(); m++) begin
        n_cmp++; if (done_cyc_q[m] !== beat_cyc_q[(m+1)*NB*LEN-1] + 2) begin n_fail++; $display("FAIL rand%0d_done_time[%0d] got=%0d exp=%0d", it, m, done_cyc_q[m], beat_cyc_q[(m+1)*NB*LEN-1] + 2); end
      end
      n_cmp++; if (rreq_double !== 0) begin n_fail++; $display("FAIL rand%0d_rreq_width got=%0d exp=0", it, rreq_double); end
    end
    gap_max = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    axi_reset = 1'b1;
    img_baddr = '0;
    begin_decoding = 1'b0;
    rand_flow = 1'b0;
    can_set = 1'b1;
    room_set = 1'b1;
    spur_en = 1'b0;
    gap_max = 0;
    beat_limit = LEN;
    repeat (3) step();
    axi_reset = 1'b0;
    step();
    test_reset();
    test_single_image();
    test_backpressure();
    test_two_images();
    test_overflow();
    test_wrap();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
